split_arbiter: RTL and testbench
================================

SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning 1 = round-robin tie-break between initiators, 0 = fixed priority to initiator 1.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, meaning tenure cycle limit when the watchdog is compiled in (range 2..255).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req1 / req2  in  1 each  bus request from initiator 1 / 2.
REQ-007 split_req  in  1  split target requests bus to return deferred read data.
REQ-008 split_start  in  1  split target issued split_ack to current owner this cycle.
REQ-009 txn_done  in  1  current transaction completed (ack seen on bus).
REQ-010 grant1 / grant2 / split_grant  out  1 each  bus ownership, one-hot or all zero.
REQ-011 split_owner  out  2  initiator awaiting split data: 0 none, 1 init1, 2 init2.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 timeout  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 States IDLE, OWN1, OWN2, SPLIT_RET; grants decode directly from the state register (grant1 = OWN1, grant2 = OWN2, split_grant = SPLIT_RET).
REQ-015 Grant latency: request sampled in IDLE at edge N yields grant high from edge N+1.
REQ-016 IDLE priority: split_req with split pending -> SPLIT_RET, above all initiator requests.
REQ-017 split_req with no split pending is ignored.
REQ-018 Initiator whose split is pending is blocked; its req is ignored until the split completes.
REQ-019 IDLE, both eligible initiators requesting: ROUND_ROBIN=1 grants the one not last served; ROUND_ROBIN=0 grants init1.
REQ-020 last_served updates on every entry to OWN1/OWN2.
REQ-021 OWNx -> IDLE on txn_done; dropping reqx while granted does not end tenure.
REQ-022 OWNx with split_start -> record split_owner = x and split pending, then -> IDLE.
REQ-023 Simultaneous split_start and txn_done in OWNx: split_start wins and the split is recorded.
REQ-024 split_start outside OWN1/OWN2 is ignored.
REQ-025 SPLIT_RET -> IDLE on txn_done; clear split pending; split_owner -> 0.
REQ-026 Every tenure is followed by at least one IDLE cycle (no back-to-back grants).
REQ-027 At most one split is outstanding; the other initiator continues to be arbitrated normally.

Reset
REQ-028 On rst: state IDLE; all grants 0; busy 0; timeout 0; split_owner 0; split pending 0; last_served = init2 (so init1 wins the first tie); watchdog counter 0.
REQ-029 rst asserted mid-tenure or mid-split drops all grants at the next edge and discards any pending split.

Configuration
REQ-030 Macro SPLIT_ARBITER_TIMEOUT_EN compiles in the watchdog.
REQ-031 With the macro: a counter clears on tenure entry and increments each cycle in OWN1/OWN2/SPLIT_RET.
REQ-032 With the macro: when the counter reaches TIMEOUT_CYCLES without txn_done, pulse timeout for one cycle and go to IDLE.
REQ-033 With the macro: expiry in SPLIT_RET also clears split pending and split_owner.
REQ-034 With the macro: txn_done on the expiry cycle takes precedence, and no timeout pulse is issued.
REQ-035 Without the macro: no counter is built, timeout is tied 0, and tenure ends only on txn_done or split_start.

Verification
REQ-036 req1 = 1 only -> grant1 at next edge; txn_done after 3 cycles -> IDLE for 1 cycle, grant1 = 0.
REQ-037 req1 = req2 = 1 continuously, ROUND_ROBIN=1, txn_done each tenure -> grants alternate 1, 2, 1, 2; with ROUND_ROBIN=0 -> grant1 only.
REQ-038 OWN1 with split_start -> split_owner = 1; req1 = req2 = 1 -> grant2 only; split_req -> split_grant; txn_done -> split_owner = 0, init1 eligible again.
REQ-039 Simultaneous split_start and txn_done in OWN2 -> split_owner = 2; split_req with no split pending -> no grant.
REQ-040 With the macro and TIMEOUT_CYCLES = 8, OWN1 with no txn_done -> timeout pulse after 8 cycles, then IDLE; without the macro -> grant1 held indefinitely.
REQ-041 rst pulsed during SPLIT_RET -> all outputs 0 next edge; split_owner = 0; a following split_req is ignored.

Source files
------------

// File: rtl/split_arbiter_if.sv
// Bus-side signal bundle for split_arbiter.
// The master side drives requests and bus events; the slave side (the arbiter) returns grants.
interface split_arbiter_if;
  logic       req1;
  logic       req2;
  logic       split_req;
  logic       split_start;
  logic       txn_done;
  logic       grant1;
  logic       grant2;
  logic       split_grant;
  logic [1:0] split_owner;
  logic       busy;
  logic       timeout;

  modport master (
    output req1, req2, split_req, split_start, txn_done,
    input  grant1, grant2, split_grant, split_owner, busy, timeout
  );

  modport slave (
    input  req1, req2, split_req, split_start, txn_done,
    output grant1, grant2, split_grant, split_owner, busy, timeout
  );
endinterface

// File: rtl/split_arbiter.sv
// Two-initiator bus arbiter with one outstanding split transaction.
// Define SPLIT_ARBITER_TIMEOUT_EN to build the tenure watchdog.
module split_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  split_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, SPLIT_RET} state_t;

  state_t     state_reg, state_next;
  logic [1:0] split_owner_reg, split_owner_next;
  logic       last_served_reg, last_served_next;   // 0 = init1, 1 = init2
  logic       split_pending;
  logic       elig1, elig2;
  logic       expire;

  // Split is pending exactly when an owner is recorded.
  assign split_pending = (split_owner_reg != 2'd0);
  assign elig1 = bus.req1 && (split_owner_reg != 2'd1);
  assign elig2 = bus.req2 && (split_owner_reg != 2'd2);

`ifdef SPLIT_ARBITER_TIMEOUT_EN
  logic [7:0] wd_cnt_reg, wd_cnt_next;
  logic       timeout_reg, timeout_next;

  assign expire       = (state_reg != IDLE) && (wd_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
  assign wd_cnt_next  = (state_reg == IDLE) ? 8'd0 : wd_cnt_reg + 8'd1;
  // A completing transfer or a split hand-off ends tenure normally, so no pulse.
  assign timeout_next = expire && !bus.txn_done &&
                        !(bus.split_start && (state_reg == OWN1 || state_reg == OWN2));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg  <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      split_owner_reg <= 2'd0;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      split_owner_reg <= split_owner_next;
      last_served_reg <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    split_owner_next = split_owner_reg;
    last_served_next = last_served_reg;
    case (state_reg)
      IDLE: begin
        if (bus.split_req && split_pending) begin
          state_next = SPLIT_RET;
        end else if (elig1 && elig2) begin
          if ((ROUND_ROBIN != 0) && !last_served_reg) begin
            state_next       = OWN2;
            last_served_next = 1'b1;
          end else begin
            state_next       = OWN1;
            last_served_next = 1'b0;
          end
        end else if (elig1) begin
          state_next       = OWN1;
          last_served_next = 1'b0;
        end else if (elig2) begin
          state_next       = OWN2;
          last_served_next = 1'b1;
        end
      end
      OWN1, OWN2: begin
        if (bus.split_start) begin
          state_next       = IDLE;
          split_owner_next = (state_reg == OWN1) ? 2'd1 : 2'd2;
        end else if (bus.txn_done || expire) begin
          state_next = IDLE;
        end
      end
      SPLIT_RET: begin
        if (bus.txn_done || expire) begin
          state_next       = IDLE;
          split_owner_next = 2'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.grant1      = (state_reg == OWN1);
  assign bus.grant2      = (state_reg == OWN2);
  assign bus.split_grant = (state_reg == SPLIT_RET);
  assign bus.split_owner = split_owner_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_split_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and fixed priority) share one stimulus
// stream and are compared cycle by cycle against a behavioural ownership model.
module tb_split_arbiter;
  localparam int TO_A = 8;
  localparam int TO_B = 8;
`ifdef SPLIT_ARBITER_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  split_arbiter_if bus_a ();
  split_arbiter_if bus_b ();

  split_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  split_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];

  // Model: owner 0 = nobody, 1/2 = initiator, 3 = split target; pend = initiator awaiting split data.
  int owner[2]  = '{0, 0};
  int pend[2]   = '{0, 0};
  int last[2]   = '{2, 2};
  int cycles[2] = '{0, 0};
  bit to[2]     = '{0, 0};

  task automatic step_model(int k, bit rr, int tmo, bit r, bit r1, bit r2, bit sq, bit ss, bit dn);
    int pick;
    bool_dummy: begin end
    if (r) begin
      owner[k] = 0; pend[k] = 0; last[k] = 2; cycles[k] = 0; to[k] = 0;
      return;
    end
    to[k] = 0;
    if (owner[k] == 0) begin
      bit want1, want2;
      want1 = r1 && pend[k] != 1;
      want2 = r2 && pend[k] != 2;
      pick = 0;
      if (sq && pend[k] != 0) pick = 3;
      else if (want1 && want2) pick = (rr && last[k] == 1) ? 2 : 1;
      else if (want1) pick = 1;
      else if (want2) pick = 2;
      if (pick != 0) begin
        owner[k]  = pick;
        cycles[k] = 0;
        if (pick != 3) begin
          last[k] = pick;
          if (k == 0) $display("[TB] dut_a grant -> %s", pick == 1 ? "init1" : "init2");
        end else if (k == 0) begin
          $display("[TB] dut_a grant -> split target (init%0d data)", pend[k]);
        end
      end
    end else if (owner[k] != 3 && ss) begin
      pend[k]  = owner[k];
      owner[k] = 0;
    end else if (dn) begin
      if (owner[k] == 3) pend[k] = 0;
      owner[k] = 0;
    end else if (WD && cycles[k] + 1 >= tmo) begin
      if (owner[k] == 3) pend[k] = 0;
      owner[k] = 0;
      to[k]    = 1'b1;
    end else begin
      cycles[k]++;
    end
  endtask

  function automatic logic [6:0] model_out(int k);
    return {owner[k] == 1, owner[k] == 2, owner[k] == 3, 2'(pend[k]), owner[k] != 0, to[k]};
  endfunction

  task automatic apply(bit r, bit r1, bit r2, bit sq, bit ss, bit dn);
    @(negedge clk);
    rst = r;
    bus_a.req1 = r1; bus_a.req2 = r2; bus_a.split_req = sq; bus_a.split_start = ss; bus_a.txn_done = dn;
    bus_b.req1 = r1; bus_b.req2 = r2; bus_b.split_req = sq; bus_b.split_start = ss; bus_b.txn_done = dn;
    step_model(0, 1'b1, TO_A, r, r1, r2, sq, ss, dn);
    exp_a.push_back(model_out(0));
    step_model(1, 1'b0, TO_B, r, r1, r2, sq, ss, dn);
    exp_b.push_back(model_out(1));
  endtask

  task automatic check(string nm, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got g1/g2/sg=%b owner=%0d busy=%b timeout=%b, expected g1/g2/sg=%b owner=%0d busy=%b timeout=%b",
               nm, $time, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: outputs settle just after the edge that consumed the queued stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0)
        check("dut_a_rr", {bus_a.grant1, bus_a.grant2, bus_a.split_grant, bus_a.split_owner, bus_a.busy, bus_a.timeout},
              exp_a.pop_front());
      if (exp_b.size() > 0)
        check("dut_b_fixed", {bus_b.grant1, bus_b.grant2, bus_b.split_grant, bus_b.split_owner, bus_b.busy, bus_b.timeout},
              exp_b.pop_front());
    end
  end

  initial begin
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    // Single requester, three-cycle tenure, then idle.
    apply(0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0);
    // Both requesting continuously: alternation vs. fixed priority.
    for (int i = 0; i < 16; i++) apply(0, 1, 1, 0, 0, (i % 2) == 1);
    apply(0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0);
    // Split by init1, init1 blocked, split return, init1 eligible again.
    apply(0, 1, 1, 0, 0, 0);
    apply(0, 1, 1, 0, 1, 0);
    apply(0, 1, 1, 0, 0, 0);
    apply(0, 1, 1, 0, 0, 1);
    apply(0, 1, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0, 1);
    apply(0, 1, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1);
    // Split and done together in OWN2; then split_req with nothing pending.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 1, 0, 1);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 1, 0, 0);
    // Tenure with no completion (watchdog when built, held grant otherwise).
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1);
    // Reset during split return, then an ignored split_req.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      apply($urandom_range(99) == 0, $urandom_range(1), $urandom_range(1),
            $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
    apply(0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations unchecked, expected 0", exp_a.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
